// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the binary32 normalize-and-round
//                stage: format constants, FSM state encoding, the packed
//                output structure and small result-building helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int               EXP_W   = 8;
    localparam int               FRAC_W  = 23;
    localparam int               BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } normState_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Signed infinity: all-ones exponent, zero fraction.
    function automatic fp32_t makeInf(input logic sign);
        fp32_t res;
        res.sign = sign;
        res.exp  = EXP_MAX;
        res.frac = '0;
        return res;
    endfunction

    // Signed zero, used when normalization runs the exponent out.
    function automatic fp32_t makeZero(input logic sign);
        fp32_t res;
        res.sign = sign;
        res.exp  = '0;
        res.frac = '0;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzc_n.sv
`default_nettype none
// ============================================================================
//  Module      : lzc_n
//  Description : Combinational leading-zero counter over an N-bit word.
//                An all-zero input reports N.
//  Revision    : 1.0 - initial release
//  Ports       : i_value  in   N      word to examine
//                o_count  out  CNT_W  number of leading zeros (0..N)
// ============================================================================
module lzc_n #(
    parameter int N     = 24,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     i_value,
    output logic [CNT_W-1:0] o_count
);

    // Scan LSB to MSB so the highest set bit makes the final assignment.
    always_comb begin
        o_count = CNT_W'(N);
        for (int i = 0; i < N; i++) begin
            if (i_value[i]) begin
                o_count = CNT_W'(N - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_round
//  Description : Post-ALU normalize and round-to-nearest-even stage of the
//                binary32 adder. Takes the aligned fraction result, ALU
//                condition codes, pre-normalization exponent and G/R/S bits,
//                and produces a packed binary32 result with Overflow,
//                Underflow and Inexact flags. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
//  Build option: NORM_LZC_EN - when defined, normalization uses a
//                leading-zero counter and completes in a single cycle;
//                otherwise it shifts one bit per cycle. Results are
//                identical, only latency differs.
//  Ports       : Clock     in   1   rising-edge clock
//                Reset_n   in   1   asynchronous active-low reset
//                InValid   in   1   input bundle valid
//                InReady   out  1   stage idle and able to accept
//                Frac      in   N   ALU fraction result
//                Carry     in   1   ALU carry out
//                Neg       in   1   ALU negative flag
//                Zero      in   1   ALU zero flag
//                EffSub    in   1   effective subtraction
//                SignIn    in   1   sign of the larger-exponent operand
//                ExpIn     in   8   biased exponent of the larger operand
//                GRS       in   3   guard/round/sticky from alignment
//                Out       out  32  packed binary32 result
//                OutValid  out  1   Out and flags valid
//                OutReady  in   1   downstream accepts
//                Overflow  out  1   result overflowed to infinity
//                Underflow out  1   result flushed to zero
//                Inexact   out  1   result was rounded
// ============================================================================
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int N = 24
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [N-1:0]     Frac,
    input  logic             Carry,
    input  logic             Neg,
    input  logic             Zero,
    input  logic             EffSub,
    input  logic             SignIn,
    input  logic [EXP_W-1:0] ExpIn,
    input  logic [2:0]       GRS,
    output logic [31:0]      Out,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Inexact
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    normState_t       r_state;
    logic [N-1:0]     r_mag;
    logic [EXP_W-1:0] r_exp;
    logic             r_g;
    logic             r_r;
    logic             r_s;
    logic             r_sign;
    fp32_t            r_out;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_inexact;

    // ------------------------------------------------------------------
    // Capture: magnitude, sign, carry-out renormalization
    // ------------------------------------------------------------------
    logic             w_effCarry;
    logic             w_zeroPath;
    logic [N-1:0]     w_negFrac;
    logic [N-1:0]     w_capMag;
    logic             w_capSign;
    logic             w_capG;
    logic             w_capR;
    logic             w_capS;
    logic [EXP_W:0]   w_capExpWide;
    logic             w_capOverflow;

    assign w_effCarry    = ~EffSub & Carry;
    assign w_zeroPath    = Zero & ~Carry;
    assign w_negFrac     = (~Frac) + {{(N-1){1'b0}}, 1'b1};
    assign w_capExpWide  = {1'b0, ExpIn} + {{EXP_W{1'b0}}, w_effCarry};
    assign w_capOverflow = (w_capExpWide >= {1'b0, EXP_MAX});

    always_comb begin
        w_capMag  = Frac;
        w_capSign = SignIn;
        w_capG    = GRS[2];
        w_capR    = GRS[1];
        w_capS    = GRS[0];
        // A negative difference means the smaller operand won: flip sign.
        if (EffSub && Neg) begin
            w_capMag  = w_negFrac;
            w_capSign = ~SignIn;
        end
        // Carry out of an add: shift right one, bits fall into G/R/S.
        if (w_effCarry) begin
            w_capMag = {1'b1, Frac[N-1:1]};
            w_capG   = Frac[0];
            w_capR   = GRS[2];
            w_capS   = GRS[1] | GRS[0];
        end
    end

    // ------------------------------------------------------------------
    // Normalization step
    // ------------------------------------------------------------------
    logic             w_normDone;
    logic             w_normFlush;
    logic             w_normToRound;
    logic [N-1:0]     w_nextMag;
    logic             w_nextG;
    logic             w_nextR;
    logic [EXP_W-1:0] w_nextExp;

`ifdef NORM_LZC_EN
    localparam int LZ_W = $clog2(N + 1);
    localparam int SH_W = N + 2;

    logic [LZ_W-1:0]  w_lzCount;
    logic [EXP_W-1:0] w_lzExt;
    logic [SH_W-1:0]  w_shifted;

    lzc_n #(
        .N (N)
    ) u_lzc (
        .i_value (r_mag),
        .o_count (w_lzCount)
    );

    assign w_lzExt       = {{(EXP_W-LZ_W){1'b0}}, w_lzCount};
    // G then R enter from the bottom with zeros behind them, exactly as
    // k single-bit shifts would deliver them.
    assign w_shifted     = {r_mag, r_g, r_r} << w_lzCount;
    assign w_normDone    = (w_lzCount == '0);
    // exp <= k means one of the k single steps would have hit zero.
    assign w_normFlush   = ~w_normDone & (r_exp <= w_lzExt);
    assign w_normToRound = 1'b1;
    assign w_nextMag     = w_shifted[SH_W-1:2];
    assign w_nextG       = w_shifted[1];
    assign w_nextR       = w_shifted[0];
    assign w_nextExp     = r_exp - w_lzExt;
`else
    assign w_normDone    = r_mag[N-1];
    // exp of 1 (or 0) would reach zero on this decrement.
    assign w_normFlush   = ~r_mag[N-1] & (r_exp <= {{(EXP_W-1){1'b0}}, 1'b1});
    assign w_normToRound = 1'b0;
    assign w_nextMag     = {r_mag[N-2:0], r_g};
    assign w_nextG       = r_r;
    assign w_nextR       = 1'b0;
    assign w_nextExp     = r_exp - {{(EXP_W-1){1'b0}}, 1'b1};
`endif

    // ------------------------------------------------------------------
    // Round to nearest even
    // ------------------------------------------------------------------
    logic             w_roundUp;
    logic [N:0]       w_rndSum;
    logic [EXP_W:0]   w_rndExpWide;
    logic             w_rndOverflow;
    logic [FRAC_W-1:0] w_rndFrac;
    logic             w_unusedHidden;

    assign w_roundUp     = r_g & (r_r | r_s | r_mag[0]);
    assign w_rndSum      = {1'b0, r_mag} + {{N{1'b0}}, w_roundUp};
    assign w_rndExpWide  = {1'b0, r_exp} + {{EXP_W{1'b0}}, w_rndSum[N]};
    assign w_rndOverflow = (w_rndExpWide >= {1'b0, EXP_MAX});
    // On a mantissa carry-out the low N bits are all zero, which is
    // already the fraction of 0x800000, so no separate mux is needed.
    assign w_rndFrac     = w_rndSum[N-2 -: FRAC_W];
    // Hidden bit is implicit in the packed format.
    assign w_unusedHidden = w_rndSum[N-1];

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_mag       <= '0;
            r_exp       <= '0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_sign      <= 1'b0;
            r_out       <= '0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        r_inReady <= 1'b0;
                        if (w_zeroPath) begin
                            r_out       <= '0;
                            r_overflow  <= 1'b0;
                            r_underflow <= 1'b0;
                            r_inexact   <= 1'b0;
                            r_outValid  <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_capOverflow) begin
                            r_out       <= makeInf(w_capSign);
                            r_overflow  <= 1'b1;
                            r_underflow <= 1'b0;
                            r_inexact   <= 1'b1;
                            r_outValid  <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_mag   <= w_capMag;
                            r_exp   <= w_capExpWide[EXP_W-1:0];
                            r_g     <= w_capG;
                            r_r     <= w_capR;
                            r_s     <= w_capS;
                            r_sign  <= w_capSign;
                            r_state <= ST_NORM;
                        end
                    end
                end

                ST_NORM: begin
                    if (w_normDone) begin
                        r_state <= ST_ROUND;
                    end else if (w_normFlush) begin
                        r_out       <= makeZero(r_sign);
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                        r_inexact   <= 1'b0;
                        r_outValid  <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_mag   <= w_nextMag;
                        r_g     <= w_nextG;
                        r_r     <= w_nextR;
                        r_exp   <= w_nextExp;
                        r_state <= w_normToRound ? ST_ROUND : ST_NORM;
                    end
                end

                ST_ROUND: begin
                    if (w_rndOverflow) begin
                        r_out      <= makeInf(r_sign);
                        r_overflow <= 1'b1;
                        r_inexact  <= 1'b1;
                    end else begin
                        r_out      <= {r_sign, w_rndExpWide[EXP_W-1:0], w_rndFrac};
                        r_overflow <= 1'b0;
                        r_inexact  <= r_g | r_r | r_s;
                    end
                    r_underflow <= 1'b0;
                    r_outValid  <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    // InReady stays low this cycle, so a simultaneous
                    // InValid is taken in the following IDLE cycle.
                    if (OutReady) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign InReady   = r_inReady;
    assign OutValid  = r_outValid;
    assign Out       = r_out;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;
    assign Inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_norm_round
//  Description : Directed self-checking bench for fp_norm_round. Expected
//                results are hand-computed binary32 values. Honours
//                NORM_LZC_EN for the expected normalization latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round;

    localparam int N = 24;

    logic          Clock    = 1'b0;
    logic          Reset_n  = 1'b1;
    logic          InValid  = 1'b0;
    logic [N-1:0]  Frac     = '0;
    logic          Carry    = 1'b0;
    logic          Neg      = 1'b0;
    logic          Zero     = 1'b0;
    logic          EffSub   = 1'b0;
    logic          SignIn   = 1'b0;
    logic [7:0]    ExpIn    = '0;
    logic [2:0]    GRS      = '0;
    logic          OutReady = 1'b1;
    logic [31:0]   Out;
    logic          InReady;
    logic          OutValid;
    logic          Overflow;
    logic          Underflow;
    logic          Inexact;

    int checkCount = 0;
    int failCount  = 0;

    always #5 Clock = ~Clock;

    fp_norm_round #(
        .N (N)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .Frac      (Frac),
        .Carry     (Carry),
        .Neg       (Neg),
        .Zero      (Zero),
        .EffSub    (EffSub),
        .SignIn    (SignIn),
        .ExpIn     (ExpIn),
        .GRS       (GRS),
        .Out       (Out),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Inexact   (Inexact)
    );

    task automatic checkEq(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: actual 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Edges after the accepting edge until OutValid: k+2 iterative, 2 with LZC.
    function automatic int normLat(input int k);
`ifdef NORM_LZC_EN
        return 2 + 0 * k;
`else
        return k + 2;
`endif
    endfunction

    task automatic driveVec(input logic effSub, input logic [N-1:0] frac,
                            input logic carry, input logic neg, input logic zero,
                            input logic signIn, input logic [7:0] expIn,
                            input logic [2:0] grs);
        EffSub = effSub;
        Frac   = frac;
        Carry  = carry;
        Neg    = neg;
        Zero   = zero;
        SignIn = signIn;
        ExpIn  = expIn;
        GRS    = grs;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (OutValid !== 1'b1 && lat < 100) begin
            @(posedge Clock);
            #1;
            lat++;
        end
    endtask

    // Flags packed as {Overflow, Underflow, Inexact}; expLat < 0 skips latency.
    task automatic runVec(input string tag, input logic effSub,
                          input logic [N-1:0] frac, input logic carry,
                          input logic neg, input logic zero, input logic signIn,
                          input logic [7:0] expIn, input logic [2:0] grs,
                          input logic [31:0] expOut, input logic [2:0] expFlags,
                          input int expLat);
        int lat;
        checkEq({tag, "_inReady"}, 32'(InReady), 32'd1);
        driveVec(effSub, frac, carry, neg, zero, signIn, expIn, grs);
        InValid = 1'b1;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        waitValid(lat);
        checkEq({tag, "_valid"}, 32'(OutValid), 32'd1);
        if (expLat >= 0) begin
            checkEq({tag, "_latency"}, lat, expLat);
        end
        checkEq({tag, "_out"}, Out, expOut);
        checkEq({tag, "_flags"}, {29'd0, Overflow, Underflow, Inexact},
                {29'd0, expFlags});
        @(posedge Clock);
        #1;
        checkEq({tag, "_drop"}, 32'(OutValid), 32'd0);
    endtask

    initial begin
        int lat;

        // Reset values
        #2 Reset_n = 1'b0;
        #1;
        checkEq("rst_inReady", 32'(InReady), 32'd1);
        checkEq("rst_outValid", 32'(OutValid), 32'd0);
        checkEq("rst_out", Out, 32'h0);
        checkEq("rst_flags", {29'd0, Overflow, Underflow, Inexact}, 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        //      tag           sub frac        cy ng zr sg exp    grs     out           flags   latency
        runVec("onePlusOne",  0, 24'h000000, 1, 0, 1, 0, 8'd127, 3'b000, 32'h40000000, 3'b000, normLat(0));
        runVec("onePtFiveM1", 1, 24'h400000, 0, 0, 0, 0, 8'd127, 3'b000, 32'h3F000000, 3'b000, normLat(1));
        runVec("oneM1PtFive", 1, 24'hC00000, 0, 1, 0, 0, 8'd127, 3'b000, 32'hBF000000, 3'b000, normLat(1));
        runVec("roundCarry",  0, 24'hFFFFFF, 0, 0, 0, 0, 8'd127, 3'b100, 32'h40000000, 3'b001, normLat(0));
        runVec("tieToEven",   0, 24'h800000, 0, 0, 0, 0, 8'd127, 3'b100, 32'h3F800000, 3'b001, normLat(0));
        runVec("tieRoundUp",  0, 24'h800001, 0, 0, 0, 0, 8'd127, 3'b100, 32'h3F800002, 3'b001, normLat(0));
        runVec("carryGrs",    0, 24'h000001, 1, 0, 0, 0, 8'd127, 3'b010, 32'h40000001, 3'b001, normLat(0));
        runVec("deepShift",   1, 24'h000003, 0, 0, 0, 1, 8'd127, 3'b110, 32'hB4F00000, 3'b000, normLat(22));
        runVec("overflow",    0, 24'h000000, 1, 0, 0, 0, 8'd254, 3'b000, 32'h7F800000, 3'b101, -1);
        runVec("underflow",   1, 24'h400000, 0, 0, 0, 0, 8'd1,   3'b000, 32'h00000000, 3'b010, -1);
        // The accepting edge itself loads the zero result.
        runVec("zeroPath",    1, 24'h000000, 0, 0, 1, 1, 8'd100, 3'b111, 32'h00000000, 3'b000, 0);
        runVec("negUnderflow",1, 24'hE00000, 0, 1, 0, 0, 8'd2,   3'b000, 32'h80000000, 3'b010, -1);
        runVec("roundToInf",  0, 24'hFFFFFF, 0, 0, 0, 0, 8'd254, 3'b100, 32'h7F800000, 3'b101, normLat(0));

        // Backpressure: result must hold while OutReady is low.
        OutReady = 1'b0;
        driveVec(1, 24'h400000, 0, 0, 0, 0, 8'd127, 3'b000);
        InValid = 1'b1;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        waitValid(lat);
        checkEq("bp_valid", 32'(OutValid), 32'd1);
        checkEq("bp_out", Out, 32'h3F000000);
        // Offer a new input while DONE; it must not be taken yet.
        driveVec(0, 24'h000000, 1, 0, 1, 0, 8'd127, 3'b000);
        InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            checkEq($sformatf("bp_hold%0d_out", i), Out, 32'h3F000000);
            checkEq($sformatf("bp_hold%0d_valid", i), 32'(OutValid), 32'd1);
            checkEq($sformatf("bp_hold%0d_inReady", i), 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        checkEq("bp_release_valid", 32'(OutValid), 32'd0);
        checkEq("bp_release_inReady", 32'(InReady), 32'd1);
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        checkEq("bp_accept_inReady", 32'(InReady), 32'd0);
        waitValid(lat);
        checkEq("bp_next_valid", 32'(OutValid), 32'd1);
        checkEq("bp_next_latency", lat, normLat(0));
        checkEq("bp_next_out", Out, 32'h40000000);
        @(posedge Clock);
        #1;

        // Asynchronous reset while in NORM discards the operation.
        driveVec(1, 24'h000003, 0, 0, 0, 1, 8'd127, 3'b110);
        InValid = 1'b1;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        #1;
        Reset_n = 1'b0;
        #1;
        checkEq("midRst_outValid", 32'(OutValid), 32'd0);
        checkEq("midRst_inReady", 32'(InReady), 32'd1);
        checkEq("midRst_out", Out, 32'h0);
        checkEq("midRst_flags", {29'd0, Overflow, Underflow, Inexact}, 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        runVec("postReset",   0, 24'h000000, 1, 0, 1, 0, 8'd127, 3'b000, 32'h40000000, 3'b000, normLat(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
